// File: rtl/drum_trigger_bank.sv
// Keycode stream to per-channel drum hit strobes and timed gates.
// Optional DRUM_RETRIGGER_EN: a new key press during GATE restarts the gate.
module drum_trigger_bank #(
  parameter int NUM_CH = 3,
  parameter int KEY_W = 8,
  parameter logic [NUM_CH*KEY_W-1:0] KEY_MAP = {8'd44, 8'd17, 8'd5},
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] GATE_LEN = 16'd4800,
  parameter logic [CNT_W-1:0] LOCKOUT_LEN = 16'd480
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [KEY_W-1:0]  note,
  input  logic              note_valid,
  output logic [NUM_CH-1:0] hit,
  output logic [NUM_CH-1:0] gate,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LOCKOUT
  } ch_state_e;

  localparam logic [CNT_W-1:0] GATE_LD = GATE_LEN - 1'b1;
  localparam logic [CNT_W-1:0] LOCK_LD = LOCKOUT_LEN - 1'b1;

  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] prev_q, prev_d;
  logic [NUM_CH-1:0] hit_q, hit_d;
  logic [NUM_CH-1:0] match, rise;
  logic [NUM_CH-1:0] lock;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      match[i] = note_valid && (note != '0) &&
                 (note == KEY_MAP[i*KEY_W +: KEY_W]);
    end
    rise   = match & ~prev_q;
    prev_d = note_valid ? match : prev_q;
  end

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            state_d[i] = GATE;
            cnt_d[i]   = GATE_LD;
            hit_d[i]   = 1'b1;
          end
        end
        GATE: begin
          if (cnt_q[i] == '0) begin
            if (LOCKOUT_LEN == '0) begin
              state_d[i] = IDLE;
            end else begin
              state_d[i] = LOCKOUT;
              cnt_d[i]   = LOCK_LD;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
`ifdef DRUM_RETRIGGER_EN
          // restart overrides end-of-gate so the gate never dips
          if (rise[i]) begin
            state_d[i] = GATE;
            cnt_d[i]   = GATE_LD;
            hit_d[i]   = 1'b1;
          end
`endif
        end
        LOCKOUT: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prev_q <= '0;
      hit_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      prev_q <= prev_d;
      hit_q  <= hit_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    gate = '0;
    lock = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gate[i] = (state_q[i] == GATE);
      lock[i] = (state_q[i] == LOCKOUT);
    end
  end

  assign hit  = hit_q;
  assign busy = |(gate | lock);

endmodule
